// File: rtl/sb_tx_shaper.sv
// -----------------------------------------------------------------------------
// sb_tx_shaper
//
// Sits between a transmitting DUT and a switchboard queue. It buffers flits in
// a 2-entry FIFO and shapes the upstream ready signal according to ready_mode,
// so the transmitter can be exercised under always-ready, pseudo-random,
// alternating or fully stalled backpressure. It also counts the flits and
// packets delivered downstream.
//
// Parameters
//   DW         flit data width in bits
//   LFSR_SEED  reset value of the ready-pattern LFSR (must be nonzero)
//
// Ports
//   clk        clock, all state on the rising edge
//   nreset     asynchronous active-low reset
//   ready_mode upstream ready pattern: 0 always, 1 pseudo-random,
//              2 alternate, 3 stall
//   in_*       upstream flit (data, dest, last) with valid/ready handshake
//   out_*      downstream flit (data, dest, last) with valid/ready handshake
//   flit_count downstream transfers completed (wraps)
//   pkt_count  downstream transfers completed with out_last=1 (wraps)
// -----------------------------------------------------------------------------
module sb_tx_shaper #(
    parameter int          DW        = 416,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [1:0]    ready_mode,
    input  logic [DW-1:0] in_data,
    input  logic [31:0]   in_dest,
    input  logic          in_last,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic [31:0]   out_dest,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   flit_count,
    output logic [31:0]   pkt_count
);

    // Galois feedback mask applied when the shifted-out bit is 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // FIFO storage: data is not reset, it is don't-care while empty.
    logic [DW-1:0] data_mem [2];
    logic [31:0]   dest_mem [2];
    logic          last_mem [2];

    logic [1:0]    count_reg;
    logic          wr_ptr_reg;
    logic          rd_ptr_reg;
    logic [15:0]   lfsr_reg;
    logic          toggle_reg;
    logic [31:0]   flit_count_reg;
    logic [31:0]   pkt_count_reg;

    logic [15:0]   lfsr_next;
    logic [1:0]    count_next;
    logic          gate;
    logic          push;
    logic          pop;

    // Gate comes from registered pattern state only; ready_mode selects
    // which pattern applies in the current cycle, so a mode change acts
    // immediately without touching the FIFO.
    always_comb begin
        gate = 1'b0;
        unique case (ready_mode)
            2'd0:    gate = 1'b1;
            2'd1:    gate = lfsr_reg[0];
            2'd2:    gate = toggle_reg;
            default: gate = 1'b0;
        endcase
    end

    // Ready depends on occupancy only, never on out_ready: a full FIFO
    // stays not-ready even in a cycle where the head is popped.
    assign in_ready  = gate && (count_reg < 2'd2);
    assign out_valid = (count_reg != 2'd0);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Head entry is driven straight from storage registers.
    assign out_data = data_mem[rd_ptr_reg];
    assign out_dest = dest_mem[rd_ptr_reg];
    assign out_last = last_mem[rd_ptr_reg];

    assign flit_count = flit_count_reg;
    assign pkt_count  = pkt_count_reg;

    assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);

    always_comb begin
        count_next = count_reg;
        unique case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= in_data;
            dest_mem[wr_ptr_reg] <= in_dest;
            last_mem[wr_ptr_reg] <= in_last;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    // Pattern generators free-run every cycle, independent of mode and
    // handshakes, so the random/alternate sequences are reproducible
    // from reset release.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lfsr_reg   <= LFSR_SEED;
            toggle_reg <= 1'b1;
        end else begin
            lfsr_reg   <= lfsr_next;
            toggle_reg <= ~toggle_reg;
        end
    end

    // Counters wrap naturally through 32-bit overflow.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            flit_count_reg <= 32'd0;
            pkt_count_reg  <= 32'd0;
        end else if (pop) begin
            flit_count_reg <= flit_count_reg + 32'd1;
            if (out_last) begin
                pkt_count_reg <= pkt_count_reg + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_sb_tx_shaper.sv
// -----------------------------------------------------------------------------
// tb_sb_tx_shaper
//
// Self-checking bench for sb_tx_shaper. A reference model (queue-based FIFO,
// LFSR/toggle pattern, counters) decides at each falling edge what the DUT
// must show and which flits are accepted; accepted flits go into a
// scoreboard queue that an independent monitor pops whenever the DUT
// delivers a flit downstream.
// -----------------------------------------------------------------------------
module tb_sb_tx_shaper;

    localparam int          DW   = 416;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        logic [DW-1:0] data;
        logic [31:0]   dest;
        logic          last;
    } flit_t;

    logic          clk = 1'b0;
    logic          nreset;
    logic [1:0]    ready_mode;
    logic [DW-1:0] in_data;
    logic [31:0]   in_dest;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [31:0]   out_dest;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   flit_count;
    logic [31:0]   pkt_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_push = 0;

    flit_t       mdl_q[$];
    flit_t       exp_q[$];
    logic [15:0] m_lfsr;
    logic        m_tog;
    logic [31:0] mdl_flit;
    logic [31:0] mdl_pkt;

    always #5 clk = ~clk;

    sb_tx_shaper #(.DW(DW), .LFSR_SEED(SEED)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .ready_mode (ready_mode),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_dest   (out_dest),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flit_count (flit_count),
        .pkt_count  (pkt_count)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < DW; k += 32) begin
            d[k +: 32] = $urandom;
        end
        return d;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Reference model: evaluated at each falling edge for the next rising edge.
    initial begin
        forever begin
            logic  gate;
            logic  exp_rdy;
            logic  push;
            logic  pop;
            flit_t f;
            @(negedge clk);
            if (!nreset) begin
                mdl_q.delete();
                exp_q.delete();
                m_lfsr   = SEED;
                m_tog    = 1'b1;
                mdl_flit = 32'd0;
                mdl_pkt  = 32'd0;
            end else begin
                case (ready_mode)
                    2'd0:    gate = 1'b1;
                    2'd1:    gate = m_lfsr[0];
                    2'd2:    gate = m_tog;
                    default: gate = 1'b0;
                endcase
                exp_rdy = gate && (mdl_q.size() < 2);
                chk("in_ready", DW'(in_ready), DW'(exp_rdy));
                chk("out_valid", DW'(out_valid), DW'(mdl_q.size() != 0));
                chk("flit_count", DW'(flit_count), DW'(mdl_flit));
                chk("pkt_count", DW'(pkt_count), DW'(mdl_pkt));
                pop  = out_ready && (mdl_q.size() != 0);
                push = in_valid && exp_rdy;
                if (pop) begin
                    f = mdl_q.pop_front();
                    mdl_flit = mdl_flit + 32'd1;
                    if (f.last) mdl_pkt = mdl_pkt + 32'd1;
                end
                if (push) begin
                    f.data = in_data;
                    f.dest = in_dest;
                    f.last = in_last;
                    mdl_q.push_back(f);
                    exp_q.push_back(f);
                    n_push++;
                end
                m_lfsr = lfsr_step(m_lfsr);
                m_tog  = ~m_tog;
            end
        end
    end

    // Monitor: pops the scoreboard on every downstream transfer.
    initial begin
        forever begin
            flit_t f;
            @(negedge clk);
            if (nreset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_flit");
                end else begin
                    f = exp_q.pop_front();
                    chk("out_data", out_data, f.data);
                    chk("out_dest", DW'(out_dest), DW'(f.dest));
                    chk("out_last", DW'(out_last), DW'(f.last));
                    $display("flit dest=%08h last=%0d", out_dest, out_last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [31:0] dst, input logic l);
        logic acc;
        acc      = 1'b0;
        in_data  = d;
        in_dest  = dst;
        in_last  = l;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) fail_now("send_timeout");
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (mdl_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (mdl_q.size() != 0) fail_now("drain_timeout");
    endtask

    // Called at posedge+1; holds reset across one rising edge.
    task automatic pulse_reset();
        nreset = 1'b0;
        #1;
        chk("rst_out_valid", DW'(out_valid), DW'(1'b0));
        chk("rst_flit_count", DW'(flit_count), '0);
        chk("rst_pkt_count", DW'(pkt_count), '0);
        @(negedge clk);
        tick();
        nreset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        int         target;
        int         cyc;

        nreset     = 1'b0;
        ready_mode = 2'd0;
        in_data    = '0;
        in_dest    = 32'd0;
        in_last    = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        #1;
        chk("reset_out_valid", DW'(out_valid), DW'(1'b0));
        chk("reset_flit_count", DW'(flit_count), '0);
        chk("reset_pkt_count", DW'(pkt_count), '0);
        tick();
        tick();
        nreset = 1'b1;

        // Passthrough
        ready_mode = 2'd0;
        out_ready  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(rand_data(), 32'h10 + 32'(i), (i == 4) || (i == 9));
        end
        drain(20);
        @(negedge clk);
        chk("pass_flit_count", DW'(flit_count), DW'(32'd10));
        chk("pass_pkt_count", DW'(pkt_count), DW'(32'd2));
        tick();

        // Backpressure
        out_ready = 1'b0;
        send(rand_data(), 32'h100, 1'b0);
        send(rand_data(), 32'h101, 1'b0);
        in_data  = rand_data();
        in_dest  = 32'h102;
        in_last  = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_full", DW'(in_ready), DW'(1'b0));
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_full_pop", DW'(in_ready), DW'(1'b0));
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready_rises", DW'(in_ready), DW'(1'b1));
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(20);

        // Alternate
        ready_mode = 2'd2;
        pulse_reset();
        pat       = 4'b0101;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = rand_data();
            in_dest = $urandom;
            in_last = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("alt_pattern", DW'(in_ready), DW'(pat[k]));
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            in_data   = rand_data();
            in_dest   = $urandom;
            in_last   = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(20);

        // Stall
        ready_mode = 2'd3;
        in_valid   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data = rand_data();
            @(negedge clk);
            chk("stall_ready", DW'(in_ready), DW'(1'b0));
            tick();
        end
        in_valid = 1'b0;

        // Random mode from reset, then random mode changes
        ready_mode = 2'd1;
        pulse_reset();
        target = n_push + 1000;
        cyc    = 0;
        while (n_push < target && cyc < 20000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = rand_data();
            in_dest   = $urandom;
            in_last   = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        if (n_push < target) fail_now("random_flits");
        for (int k = 0; k < 300; k++) begin
            ready_mode = 2'($urandom_range(0, 3));
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = rand_data();
            in_dest    = $urandom;
            in_last    = 1'($urandom_range(0, 1));
            out_ready  = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid   = 1'b0;
        ready_mode = 2'd0;
        out_ready  = 1'b1;
        drain(50);

        // Reset with flits buffered
        out_ready = 1'b0;
        send(rand_data(), 32'h200, 1'b0);
        send(rand_data(), 32'h201, 1'b1);
        pulse_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_stale", DW'(out_valid), DW'(1'b0));
            tick();
        end

        // Counter wrap
        force dut.flit_count_reg = 32'hFFFF_FFFF;
        force dut.pkt_count_reg  = 32'hFFFF_FFFF;
        mdl_flit = 32'hFFFF_FFFF;
        mdl_pkt  = 32'hFFFF_FFFF;
        #1;
        release dut.flit_count_reg;
        release dut.pkt_count_reg;
        send(rand_data(), 32'hDEAD, 1'b1);
        drain(10);
        @(negedge clk);
        chk("wrap_flit_count", DW'(flit_count), '0);
        chk("wrap_pkt_count", DW'(pkt_count), '0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
